// File: rtl/usfft_pkg.sv
// Shared types and constants for the uSFFT run sequencer.
// Lane order matches the array's output bit order on iBits/oCnt.
package usfft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int NLANES       = 8;

    localparam int LANE_C_REAL0 = 0;
    localparam int LANE_C_IMG0  = 1;
    localparam int LANE_C_REAL1 = 2;
    localparam int LANE_C_IMG1  = 3;
    localparam int LANE_D_REAL0 = 4;
    localparam int LANE_D_IMG0  = 5;
    localparam int LANE_D_REAL1 = 6;
    localparam int LANE_D_IMG1  = 7;

endpackage

// File: rtl/usfft_popcnt_lane.sv
// One output-bitstream popcount lane: cleared before a run, adds one bit per enabled cycle.
// The width is sized by the parent so a full period can never wrap.
module usfft_popcnt_lane #(
    parameter int CNTW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            sample,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNTW'(sample);
        end
    end

endmodule

// File: rtl/usfft_run_ctrl.sv
// Run sequencer for the 4-point unary stochastic FFT array: loads weights, clears,
// runs one bitstream period while popcounting the eight outputs, then flags done.
module usfft_run_ctrl #(
    parameter int BITWIDTH = 8,
    parameter int PIPE_LAT = 2,
    parameter int CNTW     = BITWIDTH + 1
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iStart,
    input  logic                iAbort,
    input  logic [BITWIDTH-1:0] iwReal,
    input  logic [BITWIDTH-1:0] iwImg,
    input  logic [7:0]          iBits,
    output logic                oLoadW,
    output logic                oClr,
    output logic [BITWIDTH-1:0] owReal,
    output logic [BITWIDTH-1:0] owImg,
    output logic                oBusy,
    output logic                oDone,
    output logic                oValid,
    output logic [8*CNTW-1:0]   oCnt
);

    import usfft_pkg::*;

    localparam int RUN_LEN = PIPE_LAT + (1 << BITWIDTH);
    localparam int CYCW    = $clog2(RUN_LEN + 1);
    localparam logic [CYCW-1:0] LAT_C  = CYCW'(PIPE_LAT);
    localparam logic [CYCW-1:0] LAST_C = CYCW'(RUN_LEN - 1);

    state_t          state;
    state_t          state_next;
    logic [CYCW-1:0] cyc;
    logic            load_next;
    logic            clr_next;
    logic            done_next;
    logic            valid_next;
    logic            accept;
    logic            lane_clr;
    logic            lane_en;

    assign accept   = (state == ST_IDLE) && iStart && !iAbort;
    assign lane_clr = (state == ST_CLEAR) && !iAbort;
    assign lane_en  = (state == ST_RUN) && !iAbort && (cyc >= LAT_C);

    always_comb begin
        state_next = state;
        load_next  = 1'b0;
        clr_next   = 1'b0;
        done_next  = 1'b0;
        valid_next = oValid;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_LOAD;
                    valid_next = 1'b0;
                end
            end
            ST_LOAD: begin
                state_next = ST_CLEAR;
                load_next  = 1'b1;
            end
            ST_CLEAR: begin
                state_next = ST_RUN;
                clr_next   = 1'b1;
            end
            ST_RUN: begin
                if (cyc == LAST_C) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
                valid_next = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort overrides everything, including a coincident start in IDLE.
        if (iAbort) begin
            state_next = ST_IDLE;
            load_next  = 1'b0;
            clr_next   = 1'b0;
            done_next  = 1'b0;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state  <= ST_IDLE;
            oLoadW <= 1'b0;
            oClr   <= 1'b0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
            oValid <= 1'b0;
            owReal <= '0;
            owImg  <= '0;
            cyc    <= '0;
        end else begin
            state  <= state_next;
            oLoadW <= load_next;
            oClr   <= clr_next;
            oBusy  <= (state_next != ST_IDLE);
            oDone  <= done_next;
            oValid <= valid_next;
            if (accept) begin
                owReal <= iwReal;
                owImg  <= iwImg;
            end
            // Counter only has meaning inside RUN; it restarts on the way in.
            if (state == ST_CLEAR) begin
                cyc <= '0;
            end else if (state == ST_RUN) begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        usfft_popcnt_lane #(
            .CNTW(CNTW)
        ) u_lane (
            .clk   (iClk),
            .rst_n (iRstN),
            .clr   (lane_clr),
            .en    (lane_en),
            .sample(iBits[k]),
            .count (oCnt[k*CNTW +: CNTW])
        );
    end

endmodule

// File: tb/tb_usfft_run_ctrl.sv
// Randomized scoreboard bench for usfft_run_ctrl against a cycle-window reference model.
module tb_usfft_run_ctrl;

    localparam int BW        = 8;
    localparam int LAT       = 2;
    localparam int CW        = BW + 1;
    localparam int NSAMP     = 1 << BW;
    localparam int RUN_START = 3;
    localparam int FIRST_CNT = RUN_START + LAT;
    localparam int LAST_CNT  = FIRST_CNT + NSAMP - 1;
    localparam int DONE_OFF  = LAST_CNT + 1;
    localparam int SPAN      = DONE_OFF + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [BW-1:0] wr_in;
    logic [BW-1:0] wi_in;
    logic [7:0]    bits;
    logic          load_w;
    logic          clr;
    logic [BW-1:0] wr_out;
    logic [BW-1:0] wi_out;
    logic          busy;
    logic          done;
    logic          valid;
    logic [8*CW-1:0] cnt;

    usfft_run_ctrl #(.BITWIDTH(BW), .PIPE_LAT(LAT), .CNTW(CW)) dut (
        .iClk  (clk),
        .iRstN (rstn),
        .iStart(start),
        .iAbort(abort),
        .iwReal(wr_in),
        .iwImg (wi_in),
        .iBits (bits),
        .oLoadW(load_w),
        .oClr  (clr),
        .owReal(wr_out),
        .owImg (wi_out),
        .oBusy (busy),
        .oDone (done),
        .oValid(valid),
        .oCnt  (cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int            due;
        logic [BW-1:0] wr;
        logic [BW-1:0] wi;
        int            lane [8];
    } exp_t;

    exp_t sb [$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: oDone must pulse exactly at each scoreboard entry's due cycle.
    always @(negedge clk) begin
        automatic bit exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        chk("done_pulse", done, exp_done);
        if (exp_done) begin
            automatic exp_t e = sb.pop_front();
            for (int k = 0; k < 8; k++)
                chk($sformatf("lane%0d_count", k), cnt[k*CW +: CW], e.lane[k]);
            chk("valid_at_done", valid, 1);
            chk("wreal_at_done", wr_out, e.wr);
            chk("wimg_at_done", wi_out, e.wi);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // mode 0: all ones, 1: lane-map pattern, 2: half density bit3, 3: random.
    task automatic run_tx(input logic [BW-1:0] wr, input logic [BW-1:0] wi, input int mode,
                          input int abort_j, input int busy_j, input int rst_j);
        logic [7:0] pat [0:SPAN];
        exp_t e;
        int e0;
        for (int j = 0; j <= SPAN; j++) begin
            case (mode)
                0: pat[j] = 8'hFF;
                1: pat[j] = (j < RUN_START) ? 8'h00 : (j < FIRST_CNT) ? 8'h01 : 8'h80;
                2: pat[j] = (j >= FIRST_CNT && ((j - FIRST_CNT) % 2 == 0)) ? 8'h08 : 8'h00;
                default: pat[j] = 8'($urandom);
            endcase
        end
        for (int k = 0; k < 8; k++) begin
            e.lane[k] = 0;
            for (int j = FIRST_CNT; j <= LAST_CNT; j++) e.lane[k] += int'(pat[j][k]);
        end
        e.wr = wr;
        e.wi = wi;

        start = 1'b1;
        wr_in = wr;
        wi_in = wi;
        bits  = pat[0];
        @(posedge clk);
        #1;
        e0 = cyc;
        e.due = e0 + DONE_OFF;
        if (abort_j == 0 && rst_j == 0) sb.push_back(e);
        start = 1'b0;
        wr_in = 8'($urandom);
        wi_in = 8'($urandom);

        for (int j = 1; j <= SPAN; j++) begin
            bits  = pat[j];
            start = (j == busy_j);
            abort = (j == abort_j);
            if (j == rst_j) rstn = 1'b0;
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            rstn  = 1'b1;
            if (j == abort_j) begin
                chk("abort_busy", busy, 0);
                chk("abort_valid", valid, 0);
                chk("abort_clr", clr, 0);
                break;
            end
            if (j == rst_j) begin
                chk("rst_busy", busy, 0);
                chk("rst_valid", valid, 0);
                chk("rst_done", done, 0);
                chk("rst_wreal", wr_out, 0);
                chk("rst_cnt_nonzero", int'(|cnt), 0);
                break;
            end
            if (j == 1) begin
                chk("loadw_rise", load_w, 1);
                chk("clr_before", clr, 0);
                chk("valid_cleared", valid, 0);
                chk("wreal_latch", wr_out, wr);
                chk("wimg_latch", wi_out, wi);
            end
            if (j == 2) begin
                chk("loadw_fall", load_w, 0);
                chk("clr_rise", clr, 1);
            end
            if (j == 3) chk("clr_fall", clr, 0);
            if (j == 100) begin
                chk("busy_mid", busy, 1);
                chk("wreal_hold", wr_out, wr);
                chk("wimg_hold", wi_out, wi);
            end
            if (j == SPAN) begin
                chk("valid_hold", valid, 1);
                chk("busy_after", busy, 0);
            end
        end
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wr_in = '0;
        wi_in = '0;
        bits  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_loadw", load_w, 0);
        chk("reset_clr", clr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", valid, 0);
        chk("reset_wreal", wr_out, 0);
        chk("reset_wimg", wi_out, 0);
        chk("reset_cnt_nonzero", int'(|cnt), 0);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bits = 8'($urandom);
            @(posedge clk);
        end
        #1;
        chk("idle_cnt_nonzero", int'(|cnt), 0);
        chk("idle_busy", busy, 0);

        run_tx(8'h40, 8'hC0, 0, 0, 0, 0);
        run_tx(8'($urandom), 8'($urandom), 1, 0, 0, 0);
        run_tx(8'($urandom), 8'($urandom), 2, 0, 0, 0);
        run_tx(8'($urandom), 8'($urandom), 3, 0, 0, 0);

        run_tx(8'($urandom), 8'($urandom), 3, RUN_START + 100, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done_busy", busy, 0);
        run_tx(8'h5A, 8'hA5, 3, 0, 0, 0);

        run_tx(8'($urandom), 8'($urandom), 3, 0, 50, 0);
        run_tx(8'($urandom), 8'($urandom), 0, 0, 0, 150);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        for (int r = 0; r < 3; r++)
            run_tx(8'($urandom), 8'($urandom), 3, 0, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
